product_accumulator: RTL and testbench

- Downstream consumer of the shift-add sequential multiplier. Captures each finished product exactly once, using the rising edge of the multiplier's level `ready`.
- Sums a programmed number of unsigned products into a wide saturating accumulator, then presents the total with a valid flag.
- Forms the accumulate half of a multi-cycle MAC path: the multiplier produces, this block reduces.

---
 rtl/product_accumulator_if.sv | 41 ++++
 rtl/product_accumulator.sv | 105 ++++++++++
 tb/tb_product_accumulator.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Bus between a shift-add multiplier consumer and the product accumulator.
// The master drives run control and the multiplier product; the slave reports the sum.
interface product_accumulator_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_WIDTH = 24,
   parameter int unsigned CNT_WIDTH = 8
);
   logic                   clear;
   logic [CNT_WIDTH-1:0]   num_terms;
   logic [2*WIDTH-1:0]     prod_in;
   logic                   prod_ready;
   logic [ACC_WIDTH-1:0]   acc_out;
   logic                   acc_valid;
   logic                   overflow;
   logic                   busy;
   logic [CNT_WIDTH-1:0]   term_count;

   modport master (
      output clear,
      output num_terms,
      output prod_in,
      output prod_ready,
      input  acc_out,
      input  acc_valid,
      input  overflow,
      input  busy,
      input  term_count
   );

   modport slave (
      input  clear,
      input  num_terms,
      input  prod_in,
      input  prod_ready,
      output acc_out,
      output acc_valid,
      output overflow,
      output busy,
      output term_count
   );
endinterface

// File: rtl/product_accumulator.sv
// Saturating accumulator for a programmed number of multiplier products; each product is
// captured once on the rising edge of the multiplier's level ready signal.
module product_accumulator #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_WIDTH = 24,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   product_accumulator_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic                   ovf_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   target_q;
   logic                   ready_q;

   logic                   take;
   logic                   last_term;
   logic                   acc_en;
   logic                   busy;
   logic                   acc_valid;
   logic [ACC_WIDTH:0]     sum;
   logic [ACC_WIDTH-1:0]   sat_sum;

   assign take      = bus.prod_ready & ~ready_q;
   // Extra counter bit keeps the comparison from wrapping at the top of the count range.
   assign last_term = ({1'b0, cnt_q} + 1'b1) == {1'b0, target_q};
   assign sum       = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 2 * WIDTH){1'b0}}, bus.prod_in};
   assign sat_sum   = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clear restarts from any state and wins over a coincident take
   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = (bus.num_terms == '0) ? StDone : StAccum;
      end else begin
         unique case (state_q)
            StIdle:  state_d = StIdle;
            StAccum: if (take && last_term) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
         endcase
      end
   end

   // Output and datapath-enable decode
   always_comb begin
      busy      = 1'b0;
      acc_valid = 1'b0;
      acc_en    = 1'b0;
      unique case (state_q)
         StIdle:  ;
         StAccum: begin
            busy   = 1'b1;
            acc_en = take & ~bus.clear;
         end
         StDone:  acc_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath; ready_q resets high so a ready already asserted at reset release is not counted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         target_q <= '0;
         ready_q  <= 1'b1;
      end else begin
         ready_q <= bus.prod_ready;
         if (bus.clear) begin
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            target_q <= bus.num_terms;
         end else if (acc_en) begin
            acc_q <= sat_sum;
            ovf_q <= ovf_q | sum[ACC_WIDTH];
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.acc_out    = acc_q;
   assign bus.acc_valid  = acc_valid;
   assign bus.overflow   = ovf_q;
   assign bus.busy       = busy;
   assign bus.term_count = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: drives a 24-bit and an 18-bit accumulator with identical stimulus and
// compares both against a saturating reference model through a scoreboard queue.
module tb_product_accumulator;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   product_accumulator_if #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus24 ();
   product_accumulator_if #(.WIDTH(8), .ACC_WIDTH(18), .CNT_WIDTH(8)) bus18 ();

   product_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) u_dut24 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus24.slave)
   );

   product_accumulator #(.WIDTH(8), .ACC_WIDTH(18), .CNT_WIDTH(8)) u_dut18 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus18.slave)
   );

   typedef struct {
      longint a24;
      longint a18;
      bit     o24;
      bit     o18;
      int     cnt;
   } exp_t;

   typedef struct {
      int               n;
      int               np;
      logic [4:0][15:0] p;
      longint           f24;
      bit               o24;
      longint           f18;
      bit               o18;
   } vec_t;

   exp_t   sb[$];
   vec_t   vecs[4];
   int     checks = 0;
   int     errors = 0;

   longint m24, m18;
   bit     mo24, mo18;
   int     mcnt, mtarget;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic [7:0] n, input logic r, input logic [15:0] p);
      bus24.clear = c; bus24.num_terms = n; bus24.prod_ready = r; bus24.prod_in = p;
      bus18.clear = c; bus18.num_terms = n; bus18.prod_ready = r; bus18.prod_in = p;
   endtask

   function automatic longint sat_add(input longint a, input longint p, input int w,
                                      inout bit ovf);
      longint mx;
      mx = (longint'(1) << w) - 1;
      if (a + p > mx) begin
         ovf = 1'b1;
         return mx;
      end
      return a + p;
   endfunction

   task automatic model_clear(input int n);
      m24 = 0; m18 = 0; mo24 = 0; mo18 = 0; mcnt = 0; mtarget = n;
   endtask

   task automatic check_status(input string tag, input logic valid, input logic bsy);
      check({tag, ".valid24"}, bus24.acc_valid, valid);
      check({tag, ".valid18"}, bus18.acc_valid, valid);
      check({tag, ".busy24"}, bus24.busy, bsy);
      check({tag, ".busy18"}, bus18.busy, bsy);
   endtask

   task automatic do_clear(input int n);
      @(negedge clk);
      drive(1'b1, 8'(n), bus24.prod_ready, bus24.prod_in);
      model_clear(n);
      @(posedge clk); #1;
      check("clr.acc24", bus24.acc_out, 0);
      check("clr.acc18", bus18.acc_out, 0);
      check("clr.cnt", bus24.term_count, 0);
      check("clr.ovf18", bus18.overflow, 0);
      check_status("clr", n == 0, n != 0);
      @(negedge clk);
      // num_terms outside a clear cycle must not affect the run
      drive(1'b0, 8'hff, bus24.prod_ready, bus24.prod_in);
   endtask

   // Present one product as a fresh low-then-high ready and score the result of that edge.
   task automatic accept(input logic [15:0] p);
      exp_t e;
      @(negedge clk);
      drive(1'b0, bus24.num_terms, 1'b0, bus24.prod_in);
      @(negedge clk);
      drive(1'b0, bus24.num_terms, 1'b1, p);
      if (mcnt < mtarget) begin
         m24 = sat_add(m24, longint'(p), 24, mo24);
         m18 = sat_add(m18, longint'(p), 18, mo18);
         mcnt++;
      end
      sb.push_back('{a24: m24, a18: m18, o24: mo24, o18: mo18, cnt: mcnt});
      @(posedge clk); #1;
      if (sb.size() == 0) begin
         check("sb.empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("acc24", bus24.acc_out, e.a24);
         check("acc18", bus18.acc_out, e.a18);
         check("ovf24", bus24.overflow, e.o24);
         check("ovf18", bus18.overflow, e.o18);
         check("cnt24", bus24.term_count, e.cnt);
         check("cnt18", bus18.term_count, e.cnt);
      end
   endtask

   initial begin
      vecs[0] = '{n: 3, np: 3, p: {16'd0, 16'd0, 16'd65025, 16'd6, 16'd225},
                  f24: 65256, o24: 0, f18: 65256, o18: 0};
      vecs[1] = '{n: 5, np: 5, p: {16'd65025, 16'd65025, 16'd65025, 16'd65025, 16'd65025},
                  f24: 325125, o24: 0, f18: 262143, o18: 1};
      vecs[2] = '{n: 0, np: 2, p: {16'd0, 16'd0, 16'd0, 16'd60, 16'd50},
                  f24: 0, o24: 0, f18: 0, o18: 0};
      vecs[3] = '{n: 2, np: 3, p: {16'd0, 16'd0, 16'd3000, 16'd2000, 16'd1000},
                  f24: 3000, o24: 0, f18: 3000, o18: 0};

      // Reset with ready already high
      rst_n = 1'b0;
      drive(1'b0, 8'd0, 1'b1, 16'd0);
      model_clear(0);
      repeat (2) @(posedge clk);
      #1;
      check("rst.acc24", bus24.acc_out, 0);
      check("rst.ovf24", bus24.overflow, 0);
      check("rst.cnt24", bus24.term_count, 0);
      check_status("rst", 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Ready high across reset release must not count
      do_clear(1);
      repeat (4) @(posedge clk);
      #1;
      check("hold.cnt", bus24.term_count, 0);
      check_status("hold", 1'b0, 1'b1);
      accept(16'd100);
      check_status("first", 1'b1, 1'b0);

      for (int v = 0; v < 4; v++) begin
         do_clear(vecs[v].n);
         for (int i = 0; i < vecs[v].np; i++) accept(vecs[v].p[i]);
         check($sformatf("v%0d.final24", v), bus24.acc_out, vecs[v].f24);
         check($sformatf("v%0d.final18", v), bus18.acc_out, vecs[v].f18);
         check($sformatf("v%0d.ovf24", v), bus24.overflow, vecs[v].o24);
         check($sformatf("v%0d.ovf18", v), bus18.overflow, vecs[v].o18);
         check($sformatf("v%0d.cnt", v), bus24.term_count,
               (vecs[v].np < vecs[v].n) ? vecs[v].np : vecs[v].n);
         check_status($sformatf("v%0d", v), 1'b1, 1'b0);
      end

      // Mid-run restart: clear coincides with a ready rise; that product is dropped
      do_clear(4);
      accept(16'd10);
      accept(16'd20);
      @(negedge clk);
      drive(1'b0, 8'hff, 1'b0, 16'd0);
      @(negedge clk);
      drive(1'b1, 8'd2, 1'b1, 16'd30);
      model_clear(2);
      @(posedge clk); #1;
      check("restart.acc", bus24.acc_out, 0);
      check("restart.cnt", bus24.term_count, 0);
      check_status("restart", 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, 8'hff, 1'b1, 16'd30);
      accept(16'd7);
      accept(16'd8);
      check("restart.final", bus24.acc_out, 15);
      check_status("restart.end", 1'b1, 1'b0);

      // Long ready-high counts once, then reset mid-run
      do_clear(2);
      accept(16'd5);
      repeat (10) @(posedge clk);
      #1;
      check("long.cnt", bus24.term_count, 1);
      check("long.acc", bus24.acc_out, 5);
      check_status("long", 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mrst.acc24", bus24.acc_out, 0);
      check("mrst.acc18", bus18.acc_out, 0);
      check("mrst.cnt", bus24.term_count, 0);
      check("mrst.ovf", bus24.overflow, 0);
      check_status("mrst", 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_status("idle", 1'b0, 1'b0);
      check("sb.left", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
